// File: rtl/pool_window_buffer_pkg.sv
// Shared definitions for the 2x2 pooling window front end.
package pool_window_buffer_pkg;

    // Default pixel width (fixed-point, passed through unmodified).
    localparam int POOL_DATA_W = 16;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2,
        DRAIN    = 2'd3
    } state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single write port, two combinational read ports.
// Storage is not reset; every entry is written before it is read in a frame.
module pool_line_buffer
    import pool_window_buffer_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int IMG_W  = 28,
    parameter int AW     = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem_q [IMG_W];

    // Write the even-row pixel into its column slot.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/pool_window_buffer.sv
// Streaming 2x2 / stride-2 window former ahead of the average-pooling unit.
// Even rows go to the line buffer; odd rows pair with it to form windows.
module pool_window_buffer
    import pool_window_buffer_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DATA_W-1:0] win_00,
    output logic [DATA_W-1:0] win_01,
    output logic [DATA_W-1:0] win_10,
    output logic [DATA_W-1:0] win_11,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_LAST_WIN = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_LAST_WIN = RW'(2 * (IMG_H / 2) - 1);
    localparam bit            H_ODD        = (IMG_H % 2) == 1;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              win_valid_q, win_valid_d;
    logic              win_last_q, win_last_d;
    logic [DATA_W-1:0] w00_q, w00_d, w01_q, w01_d, w10_q, w10_d, w11_q, w11_d;

    logic              lb_we;
    logic [DATA_W-1:0] lb_left, lb_right;
    logic              in_acc;

    pool_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .AW     (CW)
    ) u_line_buffer (
        .clk     (clk),
        .we      (lb_we),
        .waddr   (col_q),
        .wdata   (in_pixel),
        .raddr_a (col_q - CW'(1)),
        .raddr_b (col_q),
        .rdata_a (lb_left),
        .rdata_b (lb_right)
    );

    // A pending window that is not being taken this cycle blocks new pixels,
    // so an odd-column pixel can always reload the window register.
    assign in_ready  = ((state_q == EVEN_ROW) || (state_q == ODD_ROW))
                       && !(win_valid_q && !win_ready);
    assign in_acc    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN) && (!win_valid_q || win_ready);
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_00    = w00_q;
    assign win_01    = w01_q;
    assign win_10    = w10_q;
    assign win_11    = w11_q;

    // Next-state, counters, hold register and window register loading.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        hold_d      = hold_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        w00_d       = w00_q;
        w01_d       = w01_q;
        w10_d       = w10_q;
        w11_d       = w11_q;
        lb_we       = 1'b0;

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) state_d = EVEN_ROW;
            end
            EVEN_ROW: begin
                if (in_acc) begin
                    lb_we = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        // Odd-height frames end on an unpaired even row.
                        if (H_ODD && (row_q == ROW_LAST)) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = ODD_ROW;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ODD_ROW: begin
                if (in_acc) begin
                    if (col_q[0]) begin
                        w00_d       = lb_left;
                        w01_d       = lb_right;
                        w10_d       = hold_q;
                        w11_d       = in_pixel;
                        win_valid_d = 1'b1;
                        win_last_d  = (row_q == ROW_LAST_WIN) && (col_q == COL_LAST_WIN);
                    end else begin
                        // Trailing column of an odd-width row lands here and is never used.
                        hold_d = in_pixel;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = EVEN_ROW;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!win_valid_q || win_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            hold_q      <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            w00_q       <= '0;
            w01_q       <= '0;
            w10_q       <= '0;
            w11_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hold_q      <= hold_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            w00_q       <= w00_d;
            w01_q       <= w01_d;
            w10_q       <= w10_d;
            w11_q       <= w11_d;
        end
    end

endmodule
